// File: rtl/dp_stream_tx_pkg.sv
// Shared definitions for the DisplayPort-style stream transmitter:
// display bus bit positions, pixel field layout, default 1080p timing
// and the transmitter state encoding.
package dp_stream_tx_pkg;

    // Display bus layout {Vsync, Hsync, DE, RGB}
    localparam int DPO_W   = 27;
    localparam int DPO_VS  = 26;
    localparam int DPO_HS  = 25;
    localparam int DPO_DE  = 24;
    localparam int RGB_MSB = 23;
    localparam int RGB_LSB = 0;

    // FIFO word is {sof, rgb}
    localparam int FIFO_W   = 25;
    localparam int FIFO_SOF = 24;

    // Default 1080p60 timing
    localparam int DEF_H_ACTIVE   = 1920;
    localparam int DEF_H_FP       = 88;
    localparam int DEF_H_SYNC     = 44;
    localparam int DEF_H_BP       = 148;
    localparam int DEF_V_ACTIVE   = 1080;
    localparam int DEF_V_FP       = 4;
    localparam int DEF_V_SYNC     = 5;
    localparam int DEF_V_BP       = 36;
    localparam int DEF_FIFO_DEPTH = 16;

    // RGB field slices: R[23:16], G[15:8], B[7:0]
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_RUN
    } tx_state_t;

    // Assemble one display bus word from its fields
    function automatic logic [DPO_W-1:0] pack_dpo(input logic vs, input logic hs,
                                                  input logic de, input rgb_t rgb);
        logic [DPO_W-1:0] word;
        word                  = '0;
        word[DPO_VS]          = vs;
        word[DPO_HS]          = hs;
        word[DPO_DE]          = de;
        word[RGB_MSB:RGB_LSB] = rgb;
        return word;
    endfunction

endpackage

// File: rtl/dp_stream_tx_fifo.sv
// Pixel FIFO with show-ahead read: the head word is visible on rd_data
// whenever empty is low, and pop simply advances to the next entry.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module dp_pix_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; reset empties the FIFO immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_stream_tx.sv
// Video stream transmitter: buffers upstream pixels in a small FIFO,
// aligns to the start-of-frame pixel, then generates raster timing and
// drives the registered display bus {Vsync, Hsync, DE, RGB}.
module dp_stream_tx
    import dp_stream_tx_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    input  logic              pix_sof,
    output logic              pix_ready,
    input  logic              underflow_clr,
    output logic [DPO_W-1:0]  DPo,
    output logic              underflow,
    output logic [15:0]       frame_cnt
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    tx_state_t         state;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              ready_en;

    logic              fifo_push;
    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_sof;
    rgb_t              head_rgb;

    logic              de_now;
    logic              hs_now;
    logic              vs_now;
    logic              line_end;
    logic              frame_end;
    logic              starved;

    assign head_sof  = fifo_head[FIFO_SOF];
    assign head_rgb  = fifo_head[RGB_MSB:RGB_LSB];

    assign pix_ready = ready_en && !fifo_full;
    assign fifo_push = pix_valid && pix_ready;

    assign de_now    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hs_now    = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    assign vs_now    = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);
    assign line_end  = (int'(h_cnt) == H_TOTAL - 1);
    assign frame_end = line_end && (int'(v_cnt) == V_TOTAL - 1);
    assign starved   = (state == ST_RUN) && de_now && fifo_empty;

    dp_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data ({pix_sof, pix_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Pop selection: drop pre-frame words while aligning, one word per active pixel while running
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            ST_ALIGN: fifo_pop = !fifo_empty && !head_sof;
            ST_RUN:   fifo_pop = de_now && !fifo_empty;
            default:  fifo_pop = 1'b0;
        endcase
    end

    // Ready stays low through reset and rises on the first clock afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Sticky underflow flag; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end else if (starved) begin
            underflow <= 1'b1;
        end
    end

    // Transmit FSM with raster counters, frame counter and registered display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            DPo       <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    DPo   <= '0;
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) begin
                        state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    DPo <= '0;
                    if (!fifo_empty && head_sof) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    DPo <= pack_dpo(vs_now, hs_now, de_now,
                                    (de_now && !fifo_empty) ? head_rgb : rgb_t'('0));
                    if (line_end) begin
                        h_cnt <= '0;
                        if (frame_end) begin
                            v_cnt     <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            if (!en) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    DPo   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/dp_stream_tx.md
DP_STREAM_TX -- requirements
Module: dp_stream_tx

Interface
REQ-001 Parameter H_ACTIVE, default 1920, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 88 / 44 / 148, horizontal front porch, sync and back porch in clocks.
REQ-003 Parameter V_ACTIVE, default 1080, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 4 / 5 / 36, vertical front porch, sync and back porch in lines.
REQ-005 Parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of 2, at least 4).
REQ-006 clk  input  1  pixel clock, all logic on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  start/continue frame transmission.
REQ-009 pix_valid  input  1  upstream pixel word valid.
REQ-010 pix_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-011 pix_sof  input  1  marks the first pixel of a frame, qualified by pix_valid.
REQ-012 pix_ready  output  1  FIFO can accept a word.
REQ-013 underflow_clr  input  1  clears the sticky underflow flag.
REQ-014 DPo  output  27  display bus {Vsync[26], Hsync[25], DE[24], RGB[23:0]}, all syncs active-high.
REQ-015 underflow  output  1  sticky: DE cycle occurred with the FIFO empty.
REQ-016 frame_cnt  output  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-017 A word is accepted on any cycle with pix_valid && pix_ready; pix_ready = FIFO not full.
REQ-018 Simultaneous push and pop on a full FIFO is allowed; depth stays unchanged.
REQ-019 h_cnt counts 0..H_TOTAL-1, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; it wraps to 0 and v_cnt increments.
REQ-020 v_cnt counts 0..V_TOTAL-1, V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; it wraps to 0 and frame_cnt increments.
REQ-021 DE = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-022 Hsync = 1 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); this applies on every line, including vertical blanking.
REQ-023 Vsync = 1 for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for the whole line.
REQ-024 DPo is registered and reflects the counters with 1-cycle latency; RGB = 0 whenever DE = 0.
REQ-025 During DE, one FIFO word is popped per cycle and its data is driven on DPo[23:0].
REQ-026 During DE with the FIFO empty: no pop, RGB = 0, underflow set; the timing counters keep running.
REQ-027 underflow_clr has priority over a same-cycle set.
REQ-028 FSM states IDLE, ALIGN, RUN.
REQ-029 IDLE: counters held at 0, DPo = 0.
REQ-030 IDLE -> ALIGN when en = 1.
REQ-031 ALIGN: FIFO head words with sof = 0 are popped and discarded; counters are held.
REQ-032 ALIGN -> RUN when the FIFO head has sof = 1; that word is output at h_cnt = 0, v_cnt = 0.
REQ-033 RUN: free-running timing as defined above.
REQ-034 In RUN, a popped word with sof = 1 that is not at (0,0) is still output; frame alignment is not corrected mid-frame.
REQ-035 en = 0 in RUN: the current frame completes, then RUN -> IDLE at the v_cnt/h_cnt wrap, which also increments frame_cnt.
REQ-036 en = 1 at the wrap: the FSM stays in RUN with no gap frame and no realignment.

Reset
REQ-037 rst_n = 0 immediately forces state IDLE, h_cnt = 0, v_cnt = 0, FIFO empty, DPo = 0, underflow = 0, frame_cnt = 0, pix_ready = 0.
REQ-038 pix_ready = 1 from the first clock after rst_n deasserts.
REQ-039 Reset mid-frame discards all FIFO contents; no partial output follows deassertion.

Structure
REQ-040 A shared package holds the DPo bit-index constants (VS = 26, HS = 25, DE = 24), the RGB field slices, and the default 1080p timing constants.
REQ-041 The pixel FIFO is one sub-module, dp_pix_fifo: synchronous, 25-bit words {sof, rgb}, outputs full/empty.
REQ-042 dp_pix_fifo has show-ahead read, so head data is valid without a read latency.

Verification
REQ-043 All scenarios use small timing: H = 8/2/2/2 (H_TOTAL 14), V = 4/1/1/1 (V_TOTAL 7), FIFO_DEPTH 4.
REQ-044 Frame timing: preload 32 pixels 1..32, first with sof, en = 1 -> DE high for 8 clocks on each of 4 lines; RGB sequence 1..32; Hsync high at h 10-11; Vsync high for line 5; frame_cnt = 1 after 98 clocks of RUN.
REQ-045 Alignment: push 3 words with sof = 0 and values 0xAAAAAA, then sof word 0x000001 -> the 0xAA words are never on DPo; first DE pixel = 0x000001.
REQ-046 Underflow: only 5 pixels supplied -> DE pixels 6-8 of line 0 output RGB 0; underflow = 1 stays set until underflow_clr, then 0.
REQ-047 Back-pressure: FIFO full with pix_valid held -> pix_ready = 0; push and pop in the same cycle keep count at 4; no word is lost or duplicated.
REQ-048 Stop/reset: en dropped at v = 2 -> frame completes, then IDLE with DPo = 0; rst_n pulsed mid-line -> all outputs 0 asynchronously, pix_ready = 1 on the next clock.
